// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - register-file writeback merge of ALU results and formatted load returns
//
// Purpose:
//   Last pipeline stage. It owns the single write port of the 32x32 register
//   file. ALU results go straight to the port and win by default. Load returns
//   are formatted on arrival and queued in a small FIFO. The FIFO drains
//   whenever the ALU path is idle. If the ALU keeps the port busy, the FIFO
//   head takes the port once it has waited STARVE_LIMIT cycles.
//
// Ports:
//   clk, reset        - clock and asynchronous active-high reset
//   alu_valid/rd/result
//                     - ALU writeback request
//   alu_stall         - ALU request not taken this cycle; upstream holds it
//   ld_valid/ready    - load-return handshake
//   ld_rd/data/funct3/byte_off
//                     - load return: destination, raw aligned word, RISC-V
//                       funct3 and address[1:0]
//   rf_write_enable/addr/data
//                     - registered register-file write port
//   lq_count          - load FIFO occupancy

module writeback_unit #(
    parameter int LQ_DEPTH     = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alu_valid,
    input  logic [4:0]                    alu_rd,
    input  logic [31:0]                   alu_result,
    output logic                          alu_stall,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic [4:0]                    ld_rd,
    input  logic [31:0]                   ld_data,
    input  logic [2:0]                    ld_funct3,
    input  logic [1:0]                    ld_byte_off,
    output logic                          rf_write_enable,
    output logic [4:0]                    rf_write_addr,
    output logic [31:0]                   rf_write_data,
    output logic [$clog2(LQ_DEPTH+1)-1:0] lq_count
);

    localparam int PW = $clog2(LQ_DEPTH);
    localparam int CW = $clog2(LQ_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [CW-1:0] FULL_COUNT = CW'(LQ_DEPTH);
    localparam logic [SW-1:0] LIMIT      = SW'(STARVE_LIMIT);

    // FIFO storage: destination register and already-formatted data
    logic [4:0]  rd_mem   [LQ_DEPTH];
    logic [31:0] data_mem [LQ_DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve;

    logic          lq_empty;
    logic          stall_mode;
    logic          alu_write;
    logic          push;
    logic          pop;
    logic [CW-1:0] count_next;
    logic [SW-1:0] starve_next;
    logic [31:0]   formatted;

    // Byte/halfword extraction and extension by RISC-V load funct3.
    // Reserved encodings behave as LW.
    function automatic logic [31:0] format_load(
        input logic [31:0] data,
        input logic [2:0]  funct3,
        input logic [1:0]  off
    );
        logic [31:0] shifted;
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        shifted  = data >> {off, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = off[1] ? data[31:16] : data[15:0];
        case (funct3)
            3'b000:  format_load = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  format_load = {{16{half_sel[15]}}, half_sel};
            3'b100:  format_load = {24'd0, byte_sel};
            3'b101:  format_load = {16'd0, half_sel};
            default: format_load = data;
        endcase
    endfunction

    assign formatted = format_load(ld_data, ld_funct3, ld_byte_off);

    // Arbitration uses only registered state plus the current ALU request.
    // alu_stall therefore never depends on alu_valid.
    assign lq_empty   = (count == '0);
    assign stall_mode = !lq_empty && (starve >= LIMIT);
    assign alu_stall  = stall_mode;
    assign alu_write  = !stall_mode && alu_valid && (alu_rd != 5'd0);

    // The FIFO drains whenever the ALU does not take the port. This covers a
    // starvation preemption and an ALU request aimed at x0, which is consumed
    // without a write.
    assign pop  = !lq_empty && !alu_write;

    // Loads to x0 complete the handshake but are never queued
    assign push = ld_valid && ld_ready && (ld_rd != 5'd0);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Counts consecutive cycles the head has been passed over, saturating
    always_comb begin
        starve_next = starve;
        if (lq_empty || pop) begin
            starve_next = '0;
        end else if (starve != LIMIT) begin
            starve_next = starve + SW'(1);
        end
    end

    // Storage is left unreset; only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= ld_rd;
            data_mem[wr_ptr] <= formatted;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            starve          <= '0;
            ld_ready        <= 1'b0;
            rf_write_enable <= 1'b0;
            rf_write_addr   <= 5'd0;
            rf_write_data   <= 32'd0;
        end else begin
            count    <= count_next;
            starve   <= starve_next;
            // Registered from the next occupancy so ld_ready never follows ld_valid
            ld_ready <= (count_next != FULL_COUNT);

            // Pointers wrap naturally because LQ_DEPTH is a power of two
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            rf_write_enable <= pop || alu_write;
            if (pop) begin
                rf_write_addr <= rd_mem[rd_ptr];
                rf_write_data <= data_mem[rd_ptr];
            end else if (alu_write) begin
                rf_write_addr <= alu_rd;
                rf_write_data <= alu_result;
            end
        end
    end

    assign lq_count = count;

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - self-checking bench for writeback_unit

module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_result;
    logic        alu_stall;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_byte_off;
    logic        rf_write_enable;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic [2:0]  lq_count;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    // Expected writes split by destination: rd < 16 (loads, plus the ALU-only
    // test) and rd >= 16 (ALU). The order within each queue is checked exactly.
    wr_t lo_q[$];
    wr_t hi_q[$];
    wr_t mon_exp;

    writeback_unit #(.LQ_DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .alu_valid       (alu_valid),
        .alu_rd          (alu_rd),
        .alu_result      (alu_result),
        .alu_stall       (alu_stall),
        .ld_valid        (ld_valid),
        .ld_ready        (ld_ready),
        .ld_rd           (ld_rd),
        .ld_data         (ld_data),
        .ld_funct3       (ld_funct3),
        .ld_byte_off     (ld_byte_off),
        .rf_write_enable (rf_write_enable),
        .rf_write_addr   (rf_write_addr),
        .rf_write_data   (rf_write_data),
        .lq_count        (lq_count)
    );

    always #5 clk = ~clk;

    // Scoreboard: every observed write must match the front of its queue
    always @(negedge clk) begin
        if (!reset && rf_write_enable) begin
            tests_run++;
            if (rf_write_addr >= 5'd16) begin
                if (hi_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_unexpected_hi: got addr=%0d data=%h, required no write", rf_write_addr, rf_write_data);
                end else begin
                    mon_exp = hi_q.pop_front();
                    if ({rf_write_addr, rf_write_data} !== mon_exp) begin
                        tests_failed++;
                        $display("FAIL sb_hi_write: got addr=%0d data=%h, required addr=%0d data=%h",
                                 rf_write_addr, rf_write_data, mon_exp.rd, mon_exp.data);
                    end
                end
            end else begin
                if (lo_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_unexpected_lo: got addr=%0d data=%h, required no write", rf_write_addr, rf_write_data);
                end else begin
                    mon_exp = lo_q.pop_front();
                    if ({rf_write_addr, rf_write_data} !== mon_exp) begin
                        tests_failed++;
                        $display("FAIL sb_lo_write: got addr=%0d data=%h, required addr=%0d data=%h",
                                 rf_write_addr, rf_write_data, mon_exp.rd, mon_exp.data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid   = 1'b0;
        alu_rd      = 5'd0;
        alu_result  = 32'd0;
        ld_valid    = 1'b0;
        ld_rd       = 5'd0;
        ld_data     = 32'd0;
        ld_funct3   = 3'b010;
        ld_byte_off = 2'b00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        #3;
        tests_run++;
        if ({rf_write_enable, rf_write_addr, rf_write_data} !== 38'd0) begin
            tests_failed++;
            $display("FAIL reset_rf: got we=%b addr=%0d data=%h, required 0/0/0", rf_write_enable, rf_write_addr, rf_write_data);
        end
        tests_run++;
        if ({lq_count, ld_ready, alu_stall} !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_ctl: got count=%0d ready=%b stall=%b, required 0/0/0", lq_count, ld_ready, alu_stall);
        end
        tick();
        reset = 1'b0;
        tick();
        tests_run++;
        if (ld_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %b, required 1", ld_ready);
        end
    endtask

    task automatic test_alu();
        alu_valid  = 1'b1;
        alu_rd     = 5'd5;
        alu_result = 32'h1234_5678;
        lo_q.push_back({5'd5, 32'h1234_5678});
        tick();
        tests_run++;
        if ({rf_write_enable, rf_write_addr, rf_write_data} !== {1'b1, 5'd5, 32'h1234_5678}) begin
            tests_failed++;
            $display("FAIL alu_write: got we=%b addr=%0d data=%h, required 1/5/12345678", rf_write_enable, rf_write_addr, rf_write_data);
        end
        alu_valid = 1'b0;
        tick();
        tests_run++;
        if ({rf_write_enable, rf_write_addr, rf_write_data} !== {1'b0, 5'd5, 32'h1234_5678}) begin
            tests_failed++;
            $display("FAIL alu_one_cycle: got we=%b addr=%0d data=%h, required 0/5/12345678", rf_write_enable, rf_write_addr, rf_write_data);
        end
        alu_valid  = 1'b1;
        alu_rd     = 5'd0;
        alu_result = 32'hDEAD_BEEF;
        tick();
        tests_run++;
        if (rf_write_enable !== 1'b0) begin
            tests_failed++;
            $display("FAIL alu_x0: got we=%b, required 0", rf_write_enable);
        end
        idle_inputs();
        tick();
        tests_run++;
        if (lo_q.size() != 0) begin
            tests_failed++;
            $display("FAIL alu_drained: got %0d pending, required 0", lo_q.size());
        end
    endtask

    task automatic test_load_format();
        logic [2:0]  f3_tab  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [1:0]  off_tab [5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1};
        logic [31:0] exp_tab [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
        for (int i = 0; i < 5; i++) begin
            ld_valid    = 1'b1;
            ld_rd       = 5'd3;
            ld_data     = 32'h80FF_7F01;
            ld_funct3   = f3_tab[i];
            ld_byte_off = off_tab[i];
            lo_q.push_back({5'd3, exp_tab[i]});
            tick();
            ld_valid = 1'b0;
            tests_run++;
            if (lq_count !== 3'd1) begin
                tests_failed++;
                $display("FAIL fmt%0d_count: got %0d, required 1", i, lq_count);
            end
            tick();
            tests_run++;
            if ({rf_write_enable, rf_write_addr, rf_write_data} !== {1'b1, 5'd3, exp_tab[i]}) begin
                tests_failed++;
                $display("FAIL fmt%0d_write: got we=%b addr=%0d data=%h, required 1/3/%h",
                         i, rf_write_enable, rf_write_addr, rf_write_data, exp_tab[i]);
            end
        end
        // Load to x0: handshake completes, nothing is queued or written
        ld_valid = 1'b1;
        ld_rd    = 5'd0;
        tick();
        ld_valid = 1'b0;
        tests_run++;
        if (lq_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL fmt_x0_count: got %0d, required 0", lq_count);
        end
        tick();
        tests_run++;
        if (rf_write_enable !== 1'b0) begin
            tests_failed++;
            $display("FAIL fmt_x0_write: got we=%b, required 0", rf_write_enable);
        end
        idle_inputs();
    endtask

    // FIFO fills under continuous ALU traffic, then starvation preempts the ALU
    task automatic test_fill_starve();
        int  a_idx = 0;
        int  l_idx = 0;
        bit  a_acc;
        bit  l_acc;
        bit  done = 0;
        alu_valid  = 1'b1;
        alu_rd     = 5'd16;
        alu_result = 32'hA000_0000;
        hi_q.push_back({5'd16, 32'hA000_0000});
        ld_valid   = 1'b1;
        ld_rd      = 5'd1;
        ld_data    = 32'hC000_0001;
        ld_funct3  = 3'b010;
        lo_q.push_back({5'd1, 32'hC000_0001});
        for (int k = 0; k < 80 && !done; k++) begin
            @(negedge clk);
            a_acc = alu_valid && !alu_stall;
            l_acc = ld_valid && ld_ready;
            if (k < 4) begin
                tests_run++;
                if (alu_stall !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL starve_early_c%0d: got stall=%b, required 0", k, alu_stall);
                end
            end
            if (k == 4) begin
                tests_run++;
                if ({lq_count, ld_ready, alu_stall} !== {3'd4, 1'b0, 1'b1}) begin
                    tests_failed++;
                    $display("FAIL fill_full: got count=%0d ready=%b stall=%b, required 4/0/1", lq_count, ld_ready, alu_stall);
                end
            end
            if (k == 5) begin
                tests_run++;
                if ({rf_write_enable, rf_write_addr, lq_count, alu_stall} !== {1'b1, 5'd1, 3'd3, 1'b0}) begin
                    tests_failed++;
                    $display("FAIL starve_head: got we=%b addr=%0d count=%0d stall=%b, required 1/1/3/0",
                             rf_write_enable, rf_write_addr, lq_count, alu_stall);
                end
            end
            if (k == 6) begin
                tests_run++;
                if ({rf_write_enable, rf_write_addr} !== {1'b1, 5'd20}) begin
                    tests_failed++;
                    $display("FAIL starve_held_alu: got we=%b addr=%0d, required 1/20", rf_write_enable, rf_write_addr);
                end
            end
            @(posedge clk);
            #1;
            if (a_acc) begin
                a_idx++;
                if (a_idx < 10) begin
                    alu_rd     = 5'(16 + a_idx);
                    alu_result = 32'hA000_0000 + 32'(a_idx);
                    hi_q.push_back({alu_rd, alu_result});
                end else begin
                    alu_valid = 1'b0;
                end
            end
            if (l_acc) begin
                l_idx++;
                if (l_idx < 5) begin
                    ld_rd   = 5'(1 + l_idx);
                    ld_data = 32'hC000_0001 + 32'(l_idx);
                    lo_q.push_back({ld_rd, ld_data});
                end else begin
                    ld_valid = 1'b0;
                end
            end
            if (a_idx == 10 && l_idx == 5 && lq_count == 3'd0) done = 1;
        end
        tick();
        tick();
        tests_run++;
        if (!done || hi_q.size() != 0 || lo_q.size() != 0) begin
            tests_failed++;
            $display("FAIL starve_drain: got done=%0d alu_left=%0d ld_left=%0d, required 1/0/0", done, hi_q.size(), lo_q.size());
        end
        idle_inputs();
    endtask

    // Push and pop together at count 2; eight loads cross the pointer wrap
    task automatic test_back_to_back();
        int  a_idx = 0;
        int  l_idx = 0;
        bit  a_acc;
        bit  l_acc;
        bit  done = 0;
        alu_valid  = 1'b1;
        alu_rd     = 5'd17;
        alu_result = 32'hE000_0000;
        hi_q.push_back({5'd17, 32'hE000_0000});
        ld_valid   = 1'b1;
        ld_rd      = 5'd1;
        ld_data    = 32'hB000_0001;
        ld_funct3  = 3'b010;
        lo_q.push_back({5'd1, 32'hB000_0001});
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            a_acc = alu_valid && !alu_stall;
            l_acc = ld_valid && ld_ready;
            if (k >= 2 && k <= 8) begin
                tests_run++;
                if ({lq_count, ld_ready} !== {3'd2, 1'b1}) begin
                    tests_failed++;
                    $display("FAIL b2b_count_c%0d: got count=%0d ready=%b, required 2/1", k, lq_count, ld_ready);
                end
            end
            @(posedge clk);
            #1;
            if (a_acc) begin
                a_idx++;
                if (a_idx < 2) begin
                    alu_rd     = 5'(17 + a_idx);
                    alu_result = 32'hE000_0000 + 32'(a_idx);
                    hi_q.push_back({alu_rd, alu_result});
                end else begin
                    alu_valid = 1'b0;
                end
            end
            if (l_acc) begin
                l_idx++;
                if (l_idx < 8) begin
                    ld_rd   = 5'(1 + l_idx);
                    ld_data = 32'hB000_0001 + 32'(l_idx);
                    lo_q.push_back({ld_rd, ld_data});
                end else begin
                    ld_valid = 1'b0;
                end
            end
            if (a_idx == 2 && l_idx == 8 && lq_count == 3'd0) done = 1;
        end
        tick();
        tick();
        tests_run++;
        if (!done || hi_q.size() != 0 || lo_q.size() != 0) begin
            tests_failed++;
            $display("FAIL b2b_drain: got done=%0d alu_left=%0d ld_left=%0d, required 1/0/0", done, hi_q.size(), lo_q.size());
        end
        idle_inputs();
    endtask

    task automatic test_reset_midstream();
        alu_valid  = 1'b1;
        alu_rd     = 5'd20;
        alu_result = 32'h5555_0001;
        hi_q.push_back({5'd20, 32'h5555_0001});
        ld_valid   = 1'b1;
        ld_rd      = 5'd9;
        ld_data    = 32'h7777_0009;
        ld_funct3  = 3'b010;
        tick();
        // Second ALU result and both loads are cancelled by reset
        alu_rd  = 5'd21;
        alu_result = 32'h5555_0002;
        ld_rd   = 5'd10;
        ld_data = 32'h7777_000A;
        tick();
        tests_run++;
        if ({lq_count, rf_write_enable} !== {3'd2, 1'b1}) begin
            tests_failed++;
            $display("FAIL mid_pre: got count=%0d we=%b, required 2/1", lq_count, rf_write_enable);
        end
        #1;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({rf_write_enable, lq_count, ld_ready, alu_stall} !== 6'd0) begin
            tests_failed++;
            $display("FAIL mid_reset: got we=%b count=%0d ready=%b stall=%b, required 0/0/0/0",
                     rf_write_enable, lq_count, ld_ready, alu_stall);
        end
        idle_inputs();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        tests_run++;
        if (lq_count !== 3'd0 || hi_q.size() != 0) begin
            tests_failed++;
            $display("FAIL mid_after: got count=%0d alu_left=%0d, required 0/0", lq_count, hi_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_format();
        test_fill_starve();
        test_back_to_back();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
